action_input_conditioner: RTL and testbench

ACTION_INPUT_CONDITIONER -- requirements
Module: action_input_conditioner

---
 rtl/action_input_conditioner_pkg.sv | 22 ++
 rtl/action_input_conditioner_channel.sv | 167 ++++++++++++++++
 rtl/action_input_conditioner.sv | 42 ++++
 tb/tb_action_input_conditioner.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/action_input_conditioner_pkg.sv
// Shared types and default timing for the action input conditioner.
// Holds the per-channel state enum and the default cycle counts used by the top.
package GamePkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DAS  = 2'd1,
    ST_ARR  = 2'd2,
    ST_LOCK = 2'd3
  } input_state_t;

  localparam int DEF_DAS_DELAY       = 10_000_000;
  localparam int DEF_ARR_PERIOD      = 2_500_000;
  localparam int DEF_LOCKOUT         = 8_000_000;
  localparam int DEF_DEBOUNCE_CYCLES = 500_000;

  // Terminal timer value for a period of `cycles`; degenerate periods collapse to 0.
  function automatic logic [63:0] term_count(input int cycles);
    return (cycles > 0) ? 64'(cycles - 1) : 64'd0;
  endfunction

endpackage

// File: rtl/action_input_conditioner_channel.sv
// One key channel: 2-flop synchronizer, optional debounce (ACTION_INPUT_DEBOUNCE_EN),
// edge stage and the IDLE/DAS/ARR/LOCK state machine with its saturating timer.
module input_channel
  import GamePkg::*;
#(
  parameter int CNT_W           = 32,
  parameter int DAS_DELAY       = DEF_DAS_DELAY,
  parameter int ARR_PERIOD      = DEF_ARR_PERIOD,
  parameter int LOCKOUT         = DEF_LOCKOUT,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit REPEAT          = 1'b0
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       key_n,
  input  logic       clear,
  output logic       pulse,
  output logic       held,
  output logic [1:0] state_dbg
);

  localparam logic [63:0] DAS_TC  = term_count(DAS_DELAY);
  localparam logic [63:0] ARR_TC  = term_count(ARR_PERIOD);
  localparam logic [63:0] LOCK_TC = term_count(LOCKOUT);

  logic [1:0]       sync_q;
  logic             key_sync;
  logic             key_s;
  logic [1:0]       edge_q;
  logic             key_lvl;
  logic             key_rise;
  logic [1:0]       fill_cnt;
  logic             armed;
  input_state_t     state;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_inc;
  logic             das_done;
  logic             arr_done;
  logic             lock_done;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], ~key_n};
    end
  end

  assign key_sync = sync_q[1];

`ifdef ACTION_INPUT_DEBOUNCE_EN
  localparam logic [31:0] DEB_TC = 32'(term_count(DEBOUNCE_CYCLES));

  logic [31:0] deb_cnt;
  logic        deb_q;

  // Output follows the synchronizer only after DEBOUNCE_CYCLES differing samples in a row.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      deb_cnt <= '0;
      deb_q   <= 1'b0;
    end else if (key_sync == deb_q) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_TC) begin
      deb_cnt <= '0;
      deb_q   <= key_sync;
    end else begin
      deb_cnt <= deb_cnt + 32'd1;
    end
  end

  assign key_s = deb_q;
`else
  assign key_s = key_sync;
`endif

  // Arming: after reset a press only counts once the key has been seen released,
  // so a key held through reset never produces a strobe.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      edge_q   <= 2'b00;
      fill_cnt <= 2'd0;
      armed    <= 1'b0;
    end else begin
      edge_q <= {edge_q[0], key_s};
      if (fill_cnt != 2'd3) begin
        fill_cnt <= fill_cnt + 2'd1;
      end
      if (fill_cnt[1] && !key_sync) begin
        armed <= 1'b1;
      end
    end
  end

  assign key_lvl  = edge_q[0];
  assign key_rise = edge_q[0] & ~edge_q[1] & armed;

  assign timer_inc = (&timer) ? timer : timer + {{(CNT_W-1){1'b0}}, 1'b1};
  assign das_done  = (64'(timer) == DAS_TC);
  assign arr_done  = (64'(timer) == ARR_TC);
  assign lock_done = (64'(timer) == LOCK_TC);

  // Release wins over a same-cycle terminal count; clear wins over everything.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state <= ST_IDLE;
      timer <= '0;
      pulse <= 1'b0;
      held  <= 1'b0;
    end else begin
      pulse <= 1'b0;
      held  <= key_lvl;
      if (clear) begin
        state <= ST_IDLE;
        timer <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            timer <= '0;
            if (key_rise) begin
              pulse <= 1'b1;
              state <= REPEAT ? ST_DAS : ST_LOCK;
            end
          end
          ST_DAS: begin
            if (!key_lvl) begin
              state <= ST_IDLE;
              timer <= '0;
            end else if (das_done) begin
              pulse <= 1'b1;
              timer <= '0;
              state <= ST_ARR;
            end else begin
              timer <= timer_inc;
            end
          end
          ST_ARR: begin
            if (!key_lvl) begin
              state <= ST_IDLE;
              timer <= '0;
            end else if (arr_done) begin
              pulse <= 1'b1;
              timer <= '0;
            end else begin
              timer <= timer_inc;
            end
          end
          ST_LOCK: begin
            if (lock_done) begin
              state <= ST_IDLE;
              timer <= '0;
            end else begin
              timer <= timer_inc;
            end
          end
          default: begin
            state <= ST_IDLE;
            timer <= '0;
          end
        endcase
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: rtl/action_input_conditioner.sv
// Conditions NUM_CH raw active-low keys into one-cycle action strobes and held levels.
// Optional debounce stage per channel is enabled with `define ACTION_INPUT_DEBOUNCE_EN.
module action_input_conditioner
  import GamePkg::*;
#(
  parameter int              NUM_CH          = 6,
  parameter int              CNT_W           = 32,
  parameter int              DAS_DELAY       = DEF_DAS_DELAY,
  parameter int              ARR_PERIOD      = DEF_ARR_PERIOD,
  parameter int              LOCKOUT         = DEF_LOCKOUT,
  parameter int              DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic [NUM_CH-1:0] REPEAT_MASK   = 6'b001100
) (
  input  logic                clk,
  input  logic                rst_l,
  input  logic [NUM_CH-1:0]   key_n,
  input  logic                clear,
  output logic [NUM_CH-1:0]   pulse,
  output logic [NUM_CH-1:0]   held,
  output logic [2*NUM_CH-1:0] state_dbg
);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    input_channel #(
      .CNT_W           (CNT_W),
      .DAS_DELAY       (DAS_DELAY),
      .ARR_PERIOD      (ARR_PERIOD),
      .LOCKOUT         (LOCKOUT),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT          (REPEAT_MASK[ch])
    ) u_channel (
      .clk       (clk),
      .rst_l     (rst_l),
      .key_n     (key_n[ch]),
      .clear     (clear),
      .pulse     (pulse[ch]),
      .held      (held[ch]),
      .state_dbg (state_dbg[2*ch +: 2])
    );
  end

endmodule

// File: tb/tb_action_input_conditioner.sv
// Bench for action_input_conditioner: table-driven press scenarios, directed corner
// sequences and random stimulus against a cycle-level behavioural model.
module tb_action_input_conditioner;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 16;
  localparam int DAS    = 10;
  localparam int ARR    = 4;
  localparam int LOCK   = 6;
  localparam int DEB    = 5;
  localparam int W      = 2 * NUM_CH;
  localparam logic [NUM_CH-1:0] RMASK = 2'b10;

  logic              clk   = 1'b0;
  logic              rst_l = 1'b1;
  logic              clear = 1'b0;
  logic [NUM_CH-1:0] key_n = '1;
  logic [NUM_CH-1:0] pulse;
  logic [NUM_CH-1:0] held;
  logic [W-1:0]      state_dbg;

  always #5 clk = ~clk;

  action_input_conditioner #(
    .NUM_CH          (NUM_CH),
    .CNT_W           (CNT_W),
    .DAS_DELAY       (DAS),
    .ARR_PERIOD      (ARR),
    .LOCKOUT         (LOCK),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_MASK     (RMASK)
  ) dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .key_n     (key_n),
    .clear     (clear),
    .pulse     (pulse),
    .held      (held),
    .state_dbg (state_dbg)
  );

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int pulse_cnt [NUM_CH];

  // Scoreboard: expected {pulse, held} per cycle, produced by the model at each edge.
  logic [W-1:0]      exp_q [$];
  logic [NUM_CH-1:0] smp_q [$];
  bit                m_active [NUM_CH];
  bit                m_armed  [NUM_CH];
  int                m_start  [NUM_CH];

  function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Model: a press strobes 4 cycles after it reaches the pins; repeating keys strobe
  // again DAS and then every ARR cycles while held; lockout keys ignore presses for LOCK.
  task automatic model_step();
    logic [W-1:0] e;
    logic cur, prv, p;
    int n, el;
    e = '0;
    edge_n++;
    if (!rst_l) begin
      smp_q.delete();
      for (int ch = 0; ch < NUM_CH; ch++) begin
        m_active[ch] = 1'b0;
        m_armed[ch]  = 1'b0;
      end
    end else begin
      smp_q.push_back(~key_n);
      if (smp_q.size() > 5) void'(smp_q.pop_front());
      n = smp_q.size();
      for (int ch = 0; ch < NUM_CH; ch++) begin
        cur = (n >= 4) ? smp_q[n-4][ch] : 1'b0;
        prv = (n >= 5) ? smp_q[n-5][ch] : 1'b0;
        p = 1'b0;
        if (clear) begin
          m_active[ch] = 1'b0;
        end else if (m_active[ch]) begin
          el = edge_n - m_start[ch];
          if (RMASK[ch]) begin
            if (!cur) m_active[ch] = 1'b0;
            else if (el >= DAS && ((el - DAS) % ARR) == 0) p = 1'b1;
          end else if (el >= LOCK) begin
            m_active[ch] = 1'b0;
          end
        end else if (cur && !prv && m_armed[ch]) begin
          p = 1'b1;
          m_active[ch] = 1'b1;
          m_start[ch] = edge_n;
        end
        if (n >= 4 && !cur) m_armed[ch] = 1'b1;
        e[NUM_CH + ch] = p;
        e[ch] = cur;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic tick();
    logic [W-1:0] e;
    @(posedge clk);
`ifndef ACTION_INPUT_DEBOUNCE_EN
    model_step();
`endif
    @(negedge clk);
`ifndef ACTION_INPUT_DEBOUNCE_EN
    e = exp_q.pop_front();
    cmp("cycle {pulse,held}", 32'({pulse, held}), 32'(e));
`endif
    for (int ch = 0; ch < NUM_CH; ch++) pulse_cnt[ch] += int'(pulse[ch]);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic zero_counts();
    for (int ch = 0; ch < NUM_CH; ch++) pulse_cnt[ch] = 0;
  endtask

  typedef struct {
    logic [NUM_CH-1:0] press;
    int len;
    int gap;
    int exp0;
    int exp1;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{2'b10, 30, 12, 0, 6};  // ch1 strobes at 4,14,18,22,26,30
    vecs[1] = '{2'b01, 30, 12, 1, 0};  // ch0 held: single strobe
    vecs[2] = '{2'b10,  8, 12, 0, 1};  // released mid-DAS
    vecs[3] = '{2'b10, 10, 12, 0, 1};  // release lands on DAS terminal count
    vecs[4] = '{2'b10, 14, 12, 0, 2};  // release lands on ARR terminal count
    vecs[5] = '{2'b10, 15, 12, 0, 3};
    vecs[6] = '{2'b11,  3, 12, 1, 1};
    vecs[7] = '{2'b11, 20, 12, 1, 4};
    zero_counts();

    #2 rst_l = 1'b0;
    #1;
    cmp("reset pulse", 32'(pulse), 32'd0);
    cmp("reset held", 32'(held), 32'd0);
    cmp("reset state", 32'(state_dbg), 32'd0);
    run(3);
    rst_l = 1'b1;
    run(10);

`ifdef ACTION_INPUT_DEBOUNCE_EN
    zero_counts();
    key_n = 2'b00; run(3);
    key_n = 2'b11; run(30);
    cmp("deb glitch ch0", pulse_cnt[0], 0);
    cmp("deb glitch ch1", pulse_cnt[1], 0);
    zero_counts();
    key_n = 2'b00; run(8);
    key_n = 2'b11; run(30);
    cmp("deb press ch0", pulse_cnt[0], 1);
    cmp("deb press ch1", pulse_cnt[1], 1);
`else
    foreach (vecs[i]) begin
      zero_counts();
      key_n = ~vecs[i].press;
      run(vecs[i].len);
      key_n = '1;
      run(vecs[i].gap);
      cmp($sformatf("table[%0d] ch0 pulses", i), pulse_cnt[0], vecs[i].exp0);
      cmp($sformatf("table[%0d] ch1 pulses", i), pulse_cnt[1], vecs[i].exp1);
    end

    // Re-press inside lockout is swallowed; a press after lockout strobes.
    zero_counts();
    key_n = 2'b10; run(2);
    key_n = 2'b11; run(2);
    key_n = 2'b10; run(2);
    key_n = 2'b11; run(8);
    cmp("lockout repress", pulse_cnt[0], 1);
    zero_counts();
    key_n = 2'b10; run(3);
    key_n = 2'b11; run(12);
    cmp("after lockout", pulse_cnt[0], 1);

    // Simultaneous press, then clear while ch1 is auto-repeating.
    key_n = 2'b00; run(4);
    cmp("simultaneous pulse", 32'(pulse), 32'h3);
    run(16);
    clear = 1'b1; run(1);
    clear = 1'b0;
    cmp("pulse after clear", 32'(pulse), 32'd0);
    zero_counts();
    run(20);
    cmp("held after clear ch1", pulse_cnt[1], 0);
    cmp("held after clear ch0", pulse_cnt[0], 0);
    key_n = 2'b11; run(6);
    zero_counts();
    key_n = 2'b00; run(3);
    key_n = 2'b11; run(12);
    cmp("repress after clear ch0", pulse_cnt[0], 1);
    cmp("repress after clear ch1", pulse_cnt[1], 1);

    // Reset mid-ARR with the key held through reset release.
    key_n = 2'b01; run(20);
    rst_l = 1'b0;
    #1;
    cmp("async reset outputs", 32'({pulse, held}), 32'd0);
    run(3);
    rst_l = 1'b1;
    zero_counts();
    run(25);
    cmp("held through reset", pulse_cnt[1], 0);
    key_n = 2'b11; run(6);
    zero_counts();
    key_n = 2'b01; run(3);
    key_n = 2'b11; run(12);
    cmp("repress after reset", pulse_cnt[1], 1);

    // Random key activity with occasional clears.
    for (int seg = 0; seg < 120; seg++) begin
      int len;
      key_n = NUM_CH'($urandom_range(0, 3));
      len = $urandom_range(1, 25);
      for (int i = 0; i < len; i++) begin
        clear = ($urandom_range(0, 31) == 0);
        tick();
      end
      clear = 1'b0;
    end
    key_n = '1;
    run(20);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
